// File: rtl/ocpapb_fifo.sv
// ocpapb_fifo: APB-push / OCP-pop mailbox FIFO with APB status read
module ocpapb_fifo #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   apb_paddr_i,
  input  logic                    apb_psel_i,
  input  logic                    apb_penable_i,
  input  logic                    apb_pwrite_i,
  input  logic [DATA_WIDTH-1:0]   apb_pwdata_i,
  output logic [DATA_WIDTH-1:0]   apb_prdata_o,
  output logic                    apb_pready_o,
  input  logic [ADDR_WIDTH-1:0]   ocp_maddr_i,
  input  logic [2:0]              ocp_mcmd_i,
  input  logic [DATA_WIDTH-1:0]   ocp_mdata_i,
  input  logic [DATA_WIDTH/8-1:0] ocp_mbyteen_i,
  output logic                    ocp_scmdaccept_o,
  output logic [DATA_WIDTH-1:0]   ocp_sdata_o,
  output logic [1:0]              ocp_sresp_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] sresp_q, sresp_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
  logic empty, full, access, push, pop, is_read, unused;
  assign unused = ^{apb_paddr_i, ocp_maddr_i, ocp_mdata_i, ocp_mbyteen_i};
  assign empty = cnt_q == '0;
  assign full = cnt_q == CW'(FIFO_DEPTH);
  assign access = !rst && apb_psel_i && apb_penable_i;
  assign is_read = ocp_mcmd_i == 3'd2;
  assign push = access && apb_pwrite_i && !full;
  assign pop = !rst && is_read && !empty;
  assign apb_pready_o = access && (!apb_pwrite_i || !full);
  assign apb_prdata_o = DATA_WIDTH'({16'b0, 8'(cnt_q), 6'b0, full, empty});
  assign ocp_scmdaccept_o = !rst && ocp_mcmd_i != 3'd0;
  assign ocp_sresp_o = sresp_q;
  assign ocp_sdata_o = sdata_q;
  always_comb begin
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    sresp_d = (rst || ocp_mcmd_i == 3'd0) ? 2'd0 : is_read ? (empty ? 2'd2 : 2'd1) : 2'd3;
    sdata_d = pop ? mem_q[rptr_q] : '0;
  end
  always_ff @(posedge clk) begin
    sresp_q <= sresp_d;
    sdata_q <= sdata_d;
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= apb_pwdata_i;
  end
endmodule

// File: tb/tb_ocpapb_fifo.sv
// tb_ocpapb_fifo: randomized self-checking bench with queue reference model
module tb_ocpapb_fifo;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1;
  logic [31:0] paddr = 0, pwdata = 0, maddr = 0, mdata = 0;
  logic psel = 0, penable = 0, pwrite = 0;
  logic [2:0] mcmd = 0;
  logic [3:0] mbyteen = 0;
  logic [31:0] prdata, sdata;
  logic pready, scmdaccept;
  logic [1:0] sresp;
  int n_chk = 0, n_fail = 0;
  logic [31:0] q[$];
  logic [1:0] exp_resp = 0;
  logic [31:0] exp_data = 0;
  bit known = 0;
  always #5 clk = ~clk;
  ocpapb_fifo #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .apb_paddr_i(paddr), .apb_psel_i(psel), .apb_penable_i(penable),
    .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata), .apb_prdata_o(prdata),
    .apb_pready_o(pready),
    .ocp_maddr_i(maddr), .ocp_mcmd_i(mcmd), .ocp_mdata_i(mdata),
    .ocp_mbyteen_i(mbyteen), .ocp_scmdaccept_o(scmdaccept),
    .ocp_sdata_o(sdata), .ocp_sresp_o(sresp)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input bit r, input bit s, input bit e, input bit w, input logic [31:0] d, input logic [2:0] c);
    bit is_full, is_empty, did_push, acc;
    int n;
    @(negedge clk);
    rst = r; psel = s; penable = e; pwrite = w; pwdata = d; mcmd = c;
    maddr = $urandom; mdata = $urandom; paddr = $urandom; mbyteen = 4'($urandom);
    n = q.size();
    is_full = n == DEPTH;
    is_empty = n == 0;
    acc = s && e && !r;
    #1;
    check("scmdaccept", 32'(scmdaccept), 32'(!r && c != 0));
    if (s && e) check("pready", 32'(pready), 32'(acc && (!w || !is_full)));
    if (known) check("prdata", prdata, {16'h0, 8'(n), 6'h0, is_full, is_empty});
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_resp = 0;
      exp_data = 0;
      known = 1;
    end else begin
      did_push = acc && w && !is_full;
      exp_data = 0;
      if (c == 0) exp_resp = 0;
      else if (c == 2) begin
        exp_resp = is_empty ? 2'd2 : 2'd1;
        if (!is_empty) exp_data = q.pop_front();
      end else exp_resp = 3;
      if (did_push) q.push_back(d);
    end
    #1;
    if (known) begin
      check("sresp", 32'(sresp), 32'(exp_resp));
      check("sdata", sdata, exp_data);
    end
  endtask
  initial begin
    repeat (3) cyc(1, 1, 1, 1, 32'h99, 2);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 1, 1, i, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 5, 0);
    cyc(0, 1, 1, 1, 5, 2);
    cyc(0, 1, 1, 1, 5, 0);
    cyc(0, 1, 1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0, 2);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 6, 0);
    cyc(0, 1, 1, 1, 7, 0);
    cyc(0, 1, 1, 1, 32'hA, 2);
    cyc(0, 1, 1, 0, 0, 1);
    cyc(0, 1, 1, 0, 0, 5);
    repeat (3) cyc(0, 0, 0, 0, 0, 2);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 1, 32'h100 + i, 0);
    cyc(0, 1, 1, 1, 32'h200, 0);
    cyc(1, 1, 1, 1, 32'h200, 0);
    cyc(1, 1, 1, 1, 32'h200, 0);
    cyc(0, 1, 1, 1, 32'h200, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 2);
    for (int i = 0; i < 2000; i++) begin
      bit r, s, e, w;
      logic [2:0] c;
      r = $urandom_range(0, 99) == 0;
      s = $urandom_range(0, 9) != 0;
      e = $urandom_range(0, 9) != 0;
      w = $urandom_range(0, 3) != 0;
      c = $urandom_range(0, 9) < 4 ? 3'd2 : 3'($urandom);
      cyc(r, s, e, w, $urandom, c);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
